vga_rx_probe: RTL

- Receive-side decoder for the 640x480 VGA stream produced by the display path.
- Samples vga_hs, vga_vs and the 3-bit R/G/B lines on the pixel clock, then recovers the raster position and checks the sync timing.
- Reports per-frame statistics: frog grid cell and red (car) pixel count.
- Used for on-board self-test and as the checker inside display benches.

---
 rtl/vga_rx_probe_pkg.sv | 23 ++
 rtl/vga_rx_probe_if.sv | 11 +
 rtl/vga_rx_probe_sync_tracker.sv | 90 +++++++++
 rtl/vga_rx_probe.sv | 125 ++++++++++++
 4 files changed

// File: rtl/vga_rx_probe_pkg.sv
// rtl/vga_rx_probe_pkg.sv - VGA 640x480 timing, colour constants and sync FSM states
package vga_rx_probe_pkg;

    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_LINE   = 800;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_LINE   = 525;
    localparam int GRID     = 32;

    localparam logic [8:0] COL_WHITE = 9'h1FF;
    localparam logic [8:0] COL_RED   = 9'h1C0;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } sync_state_t;

endpackage

// File: rtl/vga_rx_probe_if.sv
// rtl/vga_rx_probe_if.sv - VGA sync and colour lines between display generator and probe
interface vga_rx_probe_if;
    logic       vga_hs;
    logic       vga_vs;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [2:0] vga_b;

    modport master (output vga_hs, vga_vs, vga_r, vga_g, vga_b);
    modport slave  (input  vga_hs, vga_vs, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_rx_probe_sync_tracker.sv
// rtl/vga_rx_probe_sync_tracker.sv - sync edge detect, raster position, timing checks and lock FSM
module vga_sync_tracker #(
    parameter int H_SYNC = vga_rx_probe_pkg::H_SYNC,
    parameter int H_LINE = vga_rx_probe_pkg::H_LINE,
    parameter int V_SYNC = vga_rx_probe_pkg::V_SYNC,
    parameter int V_LINE = vga_rx_probe_pkg::V_LINE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hs,
    input  logic                          vs,
    output logic [9:0]                    h_pos,
    output logic [9:0]                    v_pos,
    output vga_rx_probe_pkg::sync_state_t state,
    output logic                          vs_fall,
    output logic                          frame_evt,
    output logic                          err_evt
);
    import vga_rx_probe_pkg::*;

    logic        hs_d, vs_d;
    logic        hs_fall, hs_rise, vs_rise;
    logic        err;
    sync_state_t state_nxt;

    assign hs_fall = hs_d & ~hs;
    assign hs_rise = ~hs_d & hs;
    assign vs_fall = vs_d & ~vs;
    assign vs_rise = ~vs_d & vs;

    // h_pos/v_pos hold the position of the previous sample, so edges are checked one count early
    always_comb begin
        err = 1'b0;
        if (hs_fall && h_pos != 10'(H_LINE - 1)) err = 1'b1;
        if (hs_rise && h_pos != 10'(H_SYNC - 1)) err = 1'b1;
        if (vs_fall && (!hs_fall || v_pos != 10'(V_LINE - 1))) err = 1'b1;
        if (vs_rise && (!hs_fall || v_pos != 10'(V_SYNC - 1))) err = 1'b1;
        if (h_pos == 10'h3FF) err = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        frame_evt = 1'b0;
        err_evt   = 1'b0;
        case (state)
            ST_UNLOCKED: if (vs_fall) state_nxt = ST_ACQUIRE;
            ST_ACQUIRE: begin
                if (err) begin
                    state_nxt = ST_UNLOCKED;
                end else if (vs_fall) begin
                    state_nxt = ST_LOCKED;
                    frame_evt = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (err) begin
                    state_nxt = ST_UNLOCKED;
                    err_evt   = 1'b1;
                end else if (vs_fall) begin
                    frame_evt = 1'b1;
                end
            end
            default: state_nxt = ST_UNLOCKED;
        endcase
    end

    // v_pos is 10 bits so a full 525-line frame stays below saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_UNLOCKED;
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
            h_pos <= '0;
            v_pos <= '0;
        end else begin
            state <= state_nxt;
            hs_d  <= hs;
            vs_d  <= vs;
            if (hs_fall)
                h_pos <= '0;
            else if (h_pos != 10'h3FF)
                h_pos <= h_pos + 10'd1;
            if (vs_fall)
                v_pos <= '0;
            else if (hs_fall && v_pos != 10'h3FF)
                v_pos <= v_pos + 10'd1;
        end
    end

endmodule

// File: rtl/vga_rx_probe.sv
// rtl/vga_rx_probe.sv - VGA receive probe: pixel position recovery and per-frame statistics
module vga_rx_probe #(
    parameter int H_SYNC   = vga_rx_probe_pkg::H_SYNC,
    parameter int H_BP     = vga_rx_probe_pkg::H_BP,
    parameter int H_ACTIVE = vga_rx_probe_pkg::H_ACTIVE,
    parameter int H_LINE   = vga_rx_probe_pkg::H_LINE,
    parameter int V_SYNC   = vga_rx_probe_pkg::V_SYNC,
    parameter int V_BP     = vga_rx_probe_pkg::V_BP,
    parameter int V_ACTIVE = vga_rx_probe_pkg::V_ACTIVE,
    parameter int V_LINE   = vga_rx_probe_pkg::V_LINE,
    parameter int GRID     = vga_rx_probe_pkg::GRID
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_rx_probe_if.slave      vga,
    output logic               locked,
    output logic               px_valid,
    output logic [9:0]         px_x,
    output logic [8:0]         px_y,
    output logic [8:0]         px_rgb,
    output logic               frame_done,
    output logic               frog_found,
    output logic [4:0]         frog_col,
    output logic [3:0]         frog_row,
    output logic [18:0]        red_count,
    output logic [7:0]         err_count
);
    import vga_rx_probe_pkg::*;

    localparam logic [9:0] X0 = 10'(H_SYNC + H_BP);
    localparam logic [9:0] X1 = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] Y0 = 10'(V_SYNC + V_BP);
    localparam logic [9:0] Y1 = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam int         GRID_LOG2 = $clog2(GRID);

    logic [9:0]  h_pos, v_pos;
    sync_state_t state;
    logic        vs_fall, frame_evt, err_evt;
    logic [8:0]  rgb_d;
    logic        active;
    logic        f_found;
    logic [4:0]  f_col;
    logic [3:0]  f_row;
    logic [18:0] f_red;

    vga_sync_tracker #(
        .H_SYNC (H_SYNC),
        .H_LINE (H_LINE),
        .V_SYNC (V_SYNC),
        .V_LINE (V_LINE)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .hs        (vga.vga_hs),
        .vs        (vga.vga_vs),
        .h_pos     (h_pos),
        .v_pos     (v_pos),
        .state     (state),
        .vs_fall   (vs_fall),
        .frame_evt (frame_evt),
        .err_evt   (err_evt)
    );

    assign locked = (state == ST_LOCKED);
    assign active = (h_pos >= X0) && (h_pos < X1) && (v_pos >= Y0) && (v_pos < Y1);

    // rgb_d lines up with h_pos/v_pos; the pixel outputs register that pair one clock later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_d    <= '0;
            px_valid <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
            px_rgb   <= '0;
        end else begin
            rgb_d    <= {vga.vga_r, vga.vga_g, vga.vga_b};
            px_valid <= active && (state != ST_UNLOCKED);
            if (active && (state != ST_UNLOCKED)) begin
                px_x   <= h_pos - X0;
                px_y   <= 9'(v_pos - Y0);
                px_rgb <= rgb_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_found    <= 1'b0;
            f_col      <= '0;
            f_row      <= '0;
            f_red      <= '0;
            frame_done <= 1'b0;
            frog_found <= 1'b0;
            frog_col   <= '0;
            frog_row   <= '0;
            red_count  <= '0;
            err_count  <= '0;
        end else begin
            frame_done <= frame_evt;
            if (frame_evt) begin
                frog_found <= f_found;
                frog_col   <= f_col;
                frog_row   <= f_row;
                red_count  <= f_red;
            end
            if (vs_fall) begin
                f_found <= 1'b0;
                f_col   <= '0;
                f_row   <= '0;
                f_red   <= '0;
            end else if (px_valid) begin
                if (!f_found && px_rgb == COL_WHITE) begin
                    f_found <= 1'b1;
                    f_col   <= 5'(px_x >> GRID_LOG2);
                    f_row   <= 4'(px_y >> GRID_LOG2);
                end
                if (px_rgb == COL_RED && f_red != '1)
                    f_red <= f_red + 19'd1;
            end
            if (err_evt && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
